// File: rtl/filtro_vagas_if.sv
// Sensor-vector bus between the slot conditioner and its neighbours.
// Combinational only: carries raw sensors and sample strobe in, clean occupancy and events out.
// No backpressure: every output is a level or a single-cycle pulse.
interface filtro_vagas_if #(
  parameter int N_VAGAS = 8,
  parameter int CNT_W   = 8
);
  logic [N_VAGAS-1:0] VagasBrutas;
  logic               SampleEn;
  logic [N_VAGAS-1:0] Vagas;
  logic               Ocupou;
  logic               Liberou;
  logic [CNT_W-1:0]   ContEntradas;

  // Producer of raw sensors / consumer of the clean vector
  modport master (
    output VagasBrutas, SampleEn,
    input  Vagas, Ocupou, Liberou, ContEntradas
  );

  // The conditioner itself
  modport slave (
    input  VagasBrutas, SampleEn,
    output Vagas, Ocupou, Liberou, ContEntradas
  );
endinterface

// File: rtl/filtro_vagas.sv
// Per-slot sensor synchronizer + debouncer with arrival/departure pulses and saturating arrival count.
// Latency: 2 sync edges + DEBOUNCE qualifying SampleEn edges from raw change to Vagas update.
// No backpressure: outputs are levels and one-cycle pulses; SampleEn only paces the debounce counters.
module filtro_vagas #(
  parameter int N_VAGAS  = 8,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic            Clock,
  input  logic            ResetN,
  filtro_vagas_if.slave   bus
);

  typedef enum logic {ESTAVEL = 1'b0, CONTANDO = 1'b1} estado_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [N_VAGAS-1:0] s1_q, s2_q;
  logic [N_VAGAS-1:0] vagas_q, vagas_d;
  logic [N_VAGAS-1:0] rise, fall;
  estado_e            state_q [N_VAGAS];
  estado_e            state_d [N_VAGAS];
  logic [CNT_W-1:0]   cnt_q   [N_VAGAS];
  logic [CNT_W-1:0]   cnt_d   [N_VAGAS];
  logic [CNT_W-1:0]   cnt_base;
  logic               ocupou_q, liberou_q;
  logic [CNT_W-1:0]   cont_q, cont_d;
  logic [CNT_W:0]     n_rise, soma;

  // Two-flop synchronizer per slot; runs every edge regardless of SampleEn
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.VagasBrutas;
      s2_q <= s1_q;
    end
  end

  // Per-slot debounce FSM next state: a mismatch counts on strobes, a match always clears
  always_comb begin
    vagas_d  = vagas_q;
    cnt_base = '0;
    for (int i = 0; i < N_VAGAS; i++) begin
      state_d[i] = ESTAVEL;
      cnt_d[i]   = '0;
      if (s2_q[i] != vagas_q[i]) begin
        // Coming from ESTAVEL always starts a fresh count
        cnt_base = (state_q[i] == CONTANDO) ? cnt_q[i] : '0;
        if (!bus.SampleEn) begin
          state_d[i] = CONTANDO;
          cnt_d[i]   = cnt_base;
        end else if (cnt_base == CNT_LAST) begin
          vagas_d[i] = s2_q[i];
        end else begin
          state_d[i] = CONTANDO;
          cnt_d[i]   = cnt_base + CNT_W'(1);
        end
      end
    end
  end

  // Per-slot FSM state and counter registers
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < N_VAGAS; i++) begin
        state_q[i] <= ESTAVEL;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_VAGAS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Edge detection and saturating arrival count (sum one bit wider, then clamp)
  always_comb begin
    rise   = vagas_d & ~vagas_q;
    fall   = ~vagas_d & vagas_q;
    n_rise = '0;
    for (int i = 0; i < N_VAGAS; i++) begin
      n_rise = n_rise + (CNT_W + 1)'(rise[i]);
    end
    soma   = {1'b0, cont_q} + n_rise;
    cont_d = soma[CNT_W] ? {CNT_W{1'b1}} : soma[CNT_W-1:0];
  end

  // Clean vector, event pulses and arrival counter update together
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      vagas_q   <= '0;
      ocupou_q  <= 1'b0;
      liberou_q <= 1'b0;
      cont_q    <= '0;
    end else begin
      vagas_q   <= vagas_d;
      ocupou_q  <= |rise;
      liberou_q <= |fall;
      cont_q    <= cont_d;
    end
  end

  assign bus.Vagas        = vagas_q;
  assign bus.Ocupou       = ocupou_q;
  assign bus.Liberou      = liberou_q;
  assign bus.ContEntradas = cont_q;

endmodule

// File: tb/tb_filtro_vagas.sv
// Directed bench for filtro_vagas: reset, single-slot, glitch, simultaneous, strobed, saturation.
module tb_filtro_vagas;

  logic Clock;
  logic ResetN;
  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt;
  int   qual;

  filtro_vagas_if #(.N_VAGAS(8), .CNT_W(8)) bus ();

  filtro_vagas #(.N_VAGAS(8), .DEBOUNCE(4), .CNT_W(8)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] v, input logic oc,
                         input logic lb, input logic [7:0] c);
    chk({tag, ".Vagas"},        {24'd0, bus.Vagas},        {24'd0, v});
    chk({tag, ".Ocupou"},       {31'd0, bus.Ocupou},       {31'd0, oc});
    chk({tag, ".Liberou"},      {31'd0, bus.Liberou},      {31'd0, lb});
    chk({tag, ".ContEntradas"}, {24'd0, bus.ContEntradas}, {24'd0, c});
  endtask

  initial begin
    // Reset held with all sensors occupied: outputs must already be clear
    ResetN = 1'b0;
    bus.VagasBrutas = 8'hFF;
    bus.SampleEn = 1'b1;
    #3;
    chk_out("rst_async", 8'h00, 1'b0, 1'b0, 8'd0);
    tick();
    ResetN = 1'b1;
    ticks(5);
    chk_out("rst_e5", 8'h00, 1'b0, 1'b0, 8'd0);
    tick();
    chk_out("rst_e6", 8'hFF, 1'b1, 1'b0, 8'd8);
    tick();
    chk_out("rst_e7", 8'hFF, 1'b0, 1'b0, 8'd8);

    // All slots free
    bus.VagasBrutas = 8'h00;
    ticks(6);
    chk_out("clr_e6", 8'h00, 1'b0, 1'b1, 8'd8);
    tick();
    chk_out("clr_e7", 8'h00, 1'b0, 1'b0, 8'd8);

    // Single slot: bit 3 arrives then leaves
    bus.VagasBrutas = 8'h08;
    ticks(5);
    chk_out("b3up_e5", 8'h00, 1'b0, 1'b0, 8'd8);
    tick();
    chk_out("b3up_e6", 8'h08, 1'b1, 1'b0, 8'd9);
    tick();
    chk_out("b3up_e7", 8'h08, 1'b0, 1'b0, 8'd9);
    bus.VagasBrutas = 8'h00;
    ticks(5);
    chk_out("b3dn_e5", 8'h08, 1'b0, 1'b0, 8'd9);
    tick();
    chk_out("b3dn_e6", 8'h00, 1'b0, 1'b1, 8'd9);
    tick();
    chk_out("b3dn_e7", 8'h00, 1'b0, 1'b0, 8'd9);

    // Glitch: bit 0 high for 3 edges only
    bus.VagasBrutas = 8'h01;
    ticks(3);
    bus.VagasBrutas = 8'h00;
    for (int e = 4; e <= 9; e++) begin
      tick();
      chk_out("glitch", 8'h00, 1'b0, 1'b0, 8'd9);
    end
    chk("glitch.cnt0", {24'd0, dut.cnt_q[0]}, 32'd0);
    // Stable high afterwards is accepted
    bus.VagasBrutas = 8'h01;
    ticks(5);
    chk_out("b0up_e5", 8'h00, 1'b0, 1'b0, 8'd9);
    tick();
    chk_out("b0up_e6", 8'h01, 1'b1, 1'b0, 8'd10);

    // Simultaneous: bit 0 falls while bit 5 rises
    bus.VagasBrutas = 8'h20;
    ticks(5);
    chk_out("sim1_e5", 8'h01, 1'b0, 1'b0, 8'd10);
    tick();
    chk_out("sim1_e6", 8'h20, 1'b1, 1'b1, 8'd11);
    // Bits 1,2 rise while bit 5 falls: counter +2
    bus.VagasBrutas = 8'h06;
    ticks(5);
    chk_out("sim2_e5", 8'h20, 1'b0, 1'b0, 8'd11);
    tick();
    chk_out("sim2_e6", 8'h06, 1'b1, 1'b1, 8'd13);
    tick();
    chk_out("sim2_e7", 8'h06, 1'b0, 1'b0, 8'd13);
    bus.VagasBrutas = 8'h00;
    ticks(6);
    chk_out("sim_clr", 8'h00, 1'b0, 1'b1, 8'd13);

    // Strobed sampling, one strobe every 4 edges; bit 7 rises
    bus.VagasBrutas = 8'h80;
    qual = 0;
    for (int e = 1; e <= 22; e++) begin
      bus.SampleEn = ((e % 4) == 2);
      tick();
      if (e >= 3 && (e % 4) == 2) qual++;
      chk_out("strobe", (qual >= 4) ? 8'h80 : 8'h00,
              (e % 4 == 2) && (qual == 4), 1'b0,
              (qual >= 4) ? 8'd14 : 8'd13);
    end
    bus.SampleEn = 1'b1;
    bus.VagasBrutas = 8'h00;
    ticks(6);
    chk_out("strobe_clr", 8'h00, 1'b0, 1'b1, 8'd14);

    // Saturation: 38 rounds of 8 simultaneous arrivals
    exp_cnt = 14;
    for (int r = 0; r < 38; r++) begin
      bus.VagasBrutas = 8'hFF;
      ticks(6);
      exp_cnt = (exp_cnt + 8 > 255) ? 255 : exp_cnt + 8;
      chk("sat.cnt", {24'd0, bus.ContEntradas}, exp_cnt);
      bus.VagasBrutas = 8'h00;
      ticks(6);
    end
    chk_out("sat_hold", 8'h00, 1'b0, 1'b1, 8'd255);
    ticks(3);
    chk_out("sat_hold2", 8'h00, 1'b0, 1'b0, 8'd255);

    // Reset in the middle of a count on bit 4
    bus.VagasBrutas = 8'h10;
    ticks(4);
    chk("midrst.cnt4", {24'd0, dut.cnt_q[4]}, 32'd2);
    #2;
    ResetN = 1'b0;
    #1;
    chk_out("midrst_async", 8'h00, 1'b0, 1'b0, 8'd0);
    chk("midrst.cnt4_clr", {24'd0, dut.cnt_q[4]}, 32'd0);
    tick();
    ResetN = 1'b1;
    ticks(5);
    chk_out("midrst_e5", 8'h00, 1'b0, 1'b0, 8'd0);
    tick();
    chk_out("midrst_e6", 8'h10, 1'b1, 1'b0, 8'd1);
    tick();
    chk_out("midrst_e7", 8'h10, 1'b0, 1'b0, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
